// File: rtl/lcd12864_bus_reader.sv
// lcd12864_bus_reader: ST7920 8-bit parallel bus read master (status/data reads); LCD_RD_BF_POLL_EN enables busy-flag polling
module lcd12864_bus_reader #(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 16,
  parameter int HOLD_CYC  = 4,
  parameter int POLL_MAX  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       rd_rs,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_timeout,
  output logic       bus_busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  input  logic [7:0] lcd_dat_i
);
  localparam int M1 = SETUP_CYC > EN_CYC ? SETUP_CYC : EN_CYC;
  localparam int MX = M1 > HOLD_CYC ? M1 : HOLD_CYC;
  localparam int CW = $clog2(MX + 1);

  if (SETUP_CYC < 1 || EN_CYC < 2 || HOLD_CYC < 1 || POLL_MAX < 1) begin : g_chk
    $error("lcd12864_bus_reader: timing parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    din_q, byte_q, data_q, cap;
  logic          ready_q, valid_q, busy_q, rs_q, rw_q, en_q;
  logic          acc, last, first, again;

  assign acc   = rd_req & ready_q;
  assign last  = cnt_q == '0;
  assign first = state_q == HOLD && cnt_q == CW'(HOLD_CYC - 1);
  // the byte seen during the last EN-high cycle, also valid when HOLD is a single cycle
  assign cap   = first ? din_q : byte_q;

`ifdef LCD_RD_BF_POLL_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic [PW-1:0] att_q;
  logic          to_q, bf;
  assign bf         = ~rs_q & cap[7];
  assign again      = bf & (att_q != PW'(POLL_MAX));
  assign rd_timeout = to_q;
  always_ff @(posedge clk)
    if (rst) begin
      att_q <= '0;
      to_q  <= 1'b0;
    end else if (acc) begin
      att_q <= PW'(1);
    end else if (state_q == HOLD && last) begin
      att_q <= att_q + PW'(again);
      to_q  <= bf & ~again;
    end
`else
  assign again      = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    din_q <= lcd_dat_i;
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (first) byte_q <= din_q;
      case (state_q)
        IDLE, DONE:
          if (acc) begin
            state_q <= SETUP;
            cnt_q   <= CW'(SETUP_CYC - 1);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            rs_q    <= rd_rs;
            rw_q    <= 1'b1;
          end else state_q <= IDLE;
        SETUP:
          if (last) begin
            state_q <= EN_HI;
            cnt_q   <= CW'(EN_CYC - 1);
            en_q    <= 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
        EN_HI:
          if (last) begin
            state_q <= HOLD;
            cnt_q   <= CW'(HOLD_CYC - 1);
            en_q    <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        HOLD:
          if (!last) cnt_q <= cnt_q - 1'b1;
          else if (again) begin
            state_q <= SETUP;
            cnt_q   <= CW'(SETUP_CYC - 1);
          end else begin
            state_q <= DONE;
            valid_q <= 1'b1;
            data_q  <= cap;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
          end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_ready = ready_q;
  assign rd_valid = valid_q;
  assign rd_data  = data_q;
  assign bus_busy = busy_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = rw_q;
  assign lcd_en   = en_q;
endmodule

// File: tb/tb_lcd12864_bus_reader.sv
// tb_lcd12864_bus_reader: randomized bench checking the DUT against a cycle timeline model of the read bus cycle
module tb_lcd12864_bus_reader;
  localparam int S = 4, E = 16, H = 4, T = S + E + H, PM = 4;
`ifdef LCD_RD_BF_POLL_EN
  localparam bit POLL = 1'b1;
`else
  localparam bit POLL = 1'b0;
`endif
  // trace vector order: {lcd_en, bus_busy, rd_ready, rd_valid, lcd_rs, lcd_rw}
  localparam logic [5:0] IDLE = 6'b001000;
  localparam logic [5:0] DONE = 6'b001100;

  logic clk = 1'b0, rst = 1'b1, rd_req = 1'b0, rd_rs = 1'b0;
  logic rd_ready, rd_valid, rd_timeout, bus_busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] rd_data;
  logic [7:0] lcd_dat_i = 8'h00;
  int cyc = 0, total = 0, bad = 0, sw = 0;
  logic [7:0] va = 8'h00, vb = 8'h00, msk = 8'hFF;
  bit rnd = 1'b1;
  logic [5:0] tr [0:4095];
  logic [5:0] xv [0:4095];
  logic [7:0] bus_a [0:4095];
  logic [7:0] dat_a [0:4095];
  logic       to_a [0:4095];

  lcd12864_bus_reader #(.SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_rs(rd_rs), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_timeout(rd_timeout), .bus_busy(bus_busy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat_i(lcd_dat_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    tr[cyc]    <= {lcd_en, bus_busy, rd_ready, rd_valid, lcd_rs, lcd_rw};
    dat_a[cyc] <= rd_data;
    to_a[cyc]  <= rd_timeout;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
    lcd_dat_i = rnd ? (8'($urandom) & msk) : (cyc < sw ? va : vb);
    bus_a[cyc] = lcd_dat_i;
  endtask

  task automatic accept(input bit rs, output int n);
    rd_req = 1'b1; rd_rs = rs; tick(); n = cyc; rd_req = 1'b0;
  endtask

  task automatic wait_to(input int k);
    while (cyc <= k) tick();
  endtask

  // expected outputs for a transaction accepted at edge n made of p bus pulses
  task automatic predict(input int n, input bit rs, input int p);
    for (int j = 0; j < p * T; j++)
      xv[n+j] = {(j % T >= S) && (j % T < S + E), 1'b1, 1'b0, 1'b0, rs, 1'b1};
    xv[n+p*T] = DONE;
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick(); rst = 1'b0; tick();
    total++; if (tr[cyc-1] !== IDLE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", tr[cyc-1], IDLE); end
    total++; if (dat_a[cyc-1] !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", dat_a[cyc-1]); end
    total++; if (to_a[cyc-1] !== 1'b0) begin bad++; $display("FAIL reset_to got=%b exp=0", to_a[cyc-1]); end
  endtask

  task automatic test_status();
    int n;
    rnd = 1'b0; va = 8'h05; vb = 8'h05; sw = 0;
    accept(1'b0, n); predict(n, 1'b0, 1); wait_to(n + T);
    for (int k = n; k <= n + T; k++) begin
      total++; if (tr[k] !== xv[k]) begin bad++; $display("FAIL status_ctl cyc=%0d got=%b exp=%b", k - n, tr[k], xv[k]); end
    end
    total++; if (dat_a[n+T] !== 8'h05) begin bad++; $display("FAIL status_data got=%h exp=05", dat_a[n+T]); end
    total++; if (to_a[n+T] !== 1'b0) begin bad++; $display("FAIL status_to got=%b exp=0", to_a[n+T]); end
  endtask

  task automatic test_back_to_back();
    int n, n2;
    rnd = 1'b0; va = 8'hD3; vb = 8'hD3;
    rd_req = 1'b1; rd_rs = 1'b1; tick(); n = cyc;
    n2 = n + T + 1;
    predict(n, 1'b1, 1); predict(n2, 1'b1, 1);
    while (cyc < n2) tick();
    rd_req = 1'b0;
    wait_to(n2 + T);
    for (int k = n; k <= n2 + T; k++) begin
      total++; if (tr[k] !== xv[k]) begin bad++; $display("FAIL b2b_ctl cyc=%0d got=%b exp=%b", k - n, tr[k], xv[k]); end
    end
    total++; if (dat_a[n+T] !== 8'hD3) begin bad++; $display("FAIL b2b_data1 got=%h exp=d3", dat_a[n+T]); end
    total++; if (dat_a[n2+T] !== 8'hD3) begin bad++; $display("FAIL b2b_data2 got=%h exp=d3", dat_a[n2+T]); end
  endtask

  task automatic test_reset_mid();
    int n;
    rnd = 1'b1; msk = 8'hFF;
    accept(1'b1, n); predict(n, 1'b1, 1);
    while (cyc < n + S + 4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = n + S + 5; k <= n + T + 6; k++) xv[k] = IDLE;
    wait_to(n + T + 6);
    for (int k = n; k <= n + T + 6; k++) begin
      total++; if (tr[k] !== xv[k]) begin bad++; $display("FAIL rstmid_ctl cyc=%0d got=%b exp=%b", k - n, tr[k], xv[k]); end
    end
    total++; if (dat_a[n+S+5] !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", dat_a[n+S+5]); end
    accept(1'b1, n); predict(n, 1'b1, 1); wait_to(n + T);
    for (int k = n; k <= n + T; k++) begin
      total++; if (tr[k] !== xv[k]) begin bad++; $display("FAIL rstmid_next_ctl cyc=%0d got=%b exp=%b", k - n, tr[k], xv[k]); end
    end
    total++; if (dat_a[n+T] !== bus_a[n+S+E-1]) begin bad++; $display("FAIL rstmid_next_data got=%h exp=%h", dat_a[n+T], bus_a[n+S+E-1]); end
  endtask

  task automatic test_busy_ignored();
    int n;
    rnd = 1'b1; msk = 8'hFF;
    accept(1'b1, n); predict(n, 1'b1, 1);
    for (int i = 0; i < T; i++) begin
      rd_req = (i == 0) ? 1'b1 : 1'($urandom);
      rd_rs = 1'($urandom);
      tick();
    end
    rd_req = 1'b0;
    wait_to(n + T + 8);
    for (int k = n; k <= n + T + 8; k++) begin
      total++; if (tr[k] !== xv[k]) begin bad++; $display("FAIL busy_ctl cyc=%0d got=%b exp=%b", k - n, tr[k], xv[k]); end
    end
    total++; if (dat_a[n+T] !== bus_a[n+S+E-1]) begin bad++; $display("FAIL busy_data got=%h exp=%h", dat_a[n+T], bus_a[n+S+E-1]); end
  endtask

  task automatic test_random();
    int n;
    bit rs;
    rnd = 1'b1; msk = 8'h7F;
    repeat (8) begin
      repeat ($urandom_range(0, 3)) tick();
      rs = 1'($urandom);
      accept(rs, n); predict(n, rs, 1); wait_to(n + T);
      for (int k = n; k <= n + T; k++) begin
        total++; if (tr[k] !== xv[k]) begin bad++; $display("FAIL rand_ctl rs=%0b cyc=%0d got=%b exp=%b", rs, k - n, tr[k], xv[k]); end
      end
      total++; if (dat_a[n+T] !== bus_a[n+S+E-1]) begin bad++; $display("FAIL rand_data rs=%0b got=%h exp=%h", rs, dat_a[n+T], bus_a[n+S+E-1]); end
    end
    msk = 8'hFF;
  endtask

  task automatic test_poll_recover();
    int n, p;
    rnd = 1'b0; va = 8'h80; vb = 8'h12; sw = 32'h3FFF_FFFF;
    p = POLL ? 3 : 1;
    accept(1'b0, n);
    sw = n + T + S + E;
    predict(n, 1'b0, p); wait_to(n + p * T);
    for (int k = n; k <= n + p * T; k++) begin
      total++; if (tr[k] !== xv[k]) begin bad++; $display("FAIL poll_ok_ctl cyc=%0d got=%b exp=%b", k - n, tr[k], xv[k]); end
    end
    total++; if (dat_a[n+p*T] !== (POLL ? 8'h12 : 8'h80)) begin bad++; $display("FAIL poll_ok_data got=%h exp=%h", dat_a[n+p*T], POLL ? 8'h12 : 8'h80); end
    total++; if (to_a[n+p*T] !== 1'b0) begin bad++; $display("FAIL poll_ok_to got=%b exp=0", to_a[n+p*T]); end
  endtask

  task automatic test_poll_timeout();
    int n, p;
    rnd = 1'b0; va = 8'h8A; vb = 8'h8A; sw = 0;
    p = POLL ? PM : 1;
    accept(1'b0, n); predict(n, 1'b0, p); wait_to(n + p * T + 4);
    for (int k = n; k <= n + p * T + 4; k++) begin
      total++; if (tr[k] !== xv[k]) begin bad++; $display("FAIL poll_to_ctl cyc=%0d got=%b exp=%b", k - n, tr[k], xv[k]); end
    end
    total++; if (dat_a[n+p*T] !== 8'h8A) begin bad++; $display("FAIL poll_to_data got=%h exp=8a", dat_a[n+p*T]); end
    total++; if (to_a[n+p*T] !== POLL) begin bad++; $display("FAIL poll_to_flag got=%b exp=%b", to_a[n+p*T], POLL); end
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) xv[k] = IDLE;
    test_reset();
    test_status();
    test_back_to_back();
    test_reset_mid();
    test_busy_ignored();
    test_random();
    test_poll_recover();
    test_poll_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
